// File: rtl/nib_tx_if.sv
// ============================================================================
// nib_tx_if
//   Handshake and serial-line bundle for the nibble transmitter.
//   ed    : nibble to transmit (master -> transmitter)
//   ev    : ed valid           (master -> transmitter)
//   sr    : ready, high only while the transmitter is idle
//   stx   : serial line, idles high
//   sbusy : frame in progress, always the complement of sr
//   Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface nib_tx_if;
  logic [3:0] ed;
  logic       ev;
  logic       sr;
  logic       stx;
  logic       sbusy;

  modport master (output ed, ev, input sr, stx, sbusy);
  modport slave  (input ed, ev, output sr, stx, sbusy);
endinterface

`default_nettype wire

// File: rtl/nib_tx.sv
// ============================================================================
// nib_tx
//   Serial transmitter for 4-bit words. Accepts a nibble on a valid/ready
//   handshake and sends start, d0..d3 (LSB first), optional even parity and
//   stop, each bit held for BIT_CYCLES clocks.
//   Ports:
//     eck : clock, rising edge
//     er  : asynchronous active-high reset
//     bus : nib_tx_if.slave (ed, ev in; sr, stx, sbusy out)
//   Parameters:
//     BIT_CYCLES : clocks per serial bit, 1..255
//     PARITY_EN  : 1 inserts an even-parity bit after d3
//   Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nib_tx #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic    eck,
  input  logic    er,
  nib_tx_if.slave bus
);

  localparam int unsigned CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    idx_q,   idx_d;
  logic [3:0]    shift_q, shift_d;
  logic          par_q,   par_d;
  logic          stx_q,   stx_d;
  logic          sr_q,    sr_d;
  logic          sbusy_q, sbusy_d;

  // State register: every flop, including the outputs, resets here so an
  // abort drives the line high and ready high without waiting for a clock.
  always_ff @(posedge eck or posedge er) begin
    if (er) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stx_q   <= 1'b1;
      sr_q    <= 1'b1;
      sbusy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stx_q   <= stx_d;
      sr_q    <= sr_d;
      sbusy_q <= sbusy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;

    if (state_q == S_IDLE) begin
      if (bus.ev) begin
        shift_d = bus.ed;
        par_d   = ^bus.ed;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_START;
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      case (state_q)
        S_START: state_d = S_DATA;
        S_DATA: begin
          shift_d = {1'b0, shift_q[3:1]};
          // Leave DATA after the fourth bit rather than letting idx wrap.
          if (idx_q == 2'd3) begin
            state_d = PARITY_EN ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        S_PAR:   state_d = S_STOP;
        S_STOP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Output logic: decoded from the next state so the registered line level
  // lines up with the state it belongs to (no extra cycle of latency).
  always_comb begin
    stx_d = 1'b1;
    case (state_d)
      S_START: stx_d = 1'b0;
      S_DATA:  stx_d = shift_d[0];
      S_PAR:   stx_d = par_d;
      default: stx_d = 1'b1;
    endcase
    sr_d    = (state_d == S_IDLE);
    sbusy_d = (state_d != S_IDLE);
  end

  assign bus.stx   = stx_q;
  assign bus.sr    = sr_q;
  assign bus.sbusy = sbusy_q;

endmodule

`default_nettype wire

// File: tb/tb_nib_tx.sv
// ============================================================================
// tb_nib_tx
//   Bench for nib_tx. Three instances cover BIT_CYCLES/PARITY_EN of 4/1, 1/0
//   and 2/1. Expected line levels come from a frame model that lists the
//   framed bits and stretches each one to BIT_CYCLES clocks.
//   Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nib_tx;

  logic eck = 1'b0;
  logic er  = 1'b1;
  always #5 eck = ~eck;

  int checks = 0;
  int errors = 0;

  logic [3:0] ed_r [3];
  logic       ev_r [3];

  int unsigned BCS  [3] = '{4, 1, 2};
  bit          PENS [3] = '{1'b1, 1'b0, 1'b1};

  nib_tx_if bus0 ();
  nib_tx_if bus1 ();
  nib_tx_if bus2 ();

  assign bus0.ed = ed_r[0];
  assign bus0.ev = ev_r[0];
  assign bus1.ed = ed_r[1];
  assign bus1.ev = ev_r[1];
  assign bus2.ed = ed_r[2];
  assign bus2.ev = ev_r[2];

  nib_tx #(.BIT_CYCLES(4), .PARITY_EN(1'b1)) u_dut0 (.eck(eck), .er(er), .bus(bus0));
  nib_tx #(.BIT_CYCLES(1), .PARITY_EN(1'b0)) u_dut1 (.eck(eck), .er(er), .bus(bus1));
  nib_tx #(.BIT_CYCLES(2), .PARITY_EN(1'b1)) u_dut2 (.eck(eck), .er(er), .bus(bus2));

  function automatic logic get_stx(int i);
    case (i)
      0:       return bus0.stx;
      1:       return bus1.stx;
      default: return bus2.stx;
    endcase
  endfunction

  function automatic logic get_sr(int i);
    case (i)
      0:       return bus0.sr;
      1:       return bus1.sr;
      default: return bus2.sr;
    endcase
  endfunction

  function automatic logic get_busy(int i);
    case (i)
      0:       return bus0.sbusy;
      1:       return bus1.sbusy;
      default: return bus2.sbusy;
    endcase
  endfunction

  task automatic step();
    @(posedge eck);
    #1;
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(int i, string tag);
    chk($sformatf("u%0d %s stx", i, tag),   get_stx(i),  1'b1);
    chk($sformatf("u%0d %s sr", i, tag),    get_sr(i),   1'b1);
    chk($sformatf("u%0d %s sbusy", i, tag), get_busy(i), 1'b0);
  endtask

  // Called one delta after the accepting edge. Walks the expected frame
  // cycle by cycle; inject_at >= 0 pulses ev with a different nibble for one
  // cycle mid-frame; stop_after >= 0 returns early at that frame cycle.
  task automatic check_frame(int i, logic [3:0] nib, int inject_at, int stop_after);
    logic bits [$];
    logic line [$];
    int   bc;
    bc = int'(BCS[i]);
    bits.push_back(1'b0);
    for (int k = 0; k < 4; k++) bits.push_back(nib[k]);
    if (PENS[i]) bits.push_back(^nib);
    bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int r = 0; r < bc; r++) line.push_back(bits[b]);
    end

    for (int j = 0; j < line.size(); j++) begin
      if (j == stop_after) return;
      if (inject_at >= 0 && j == inject_at) begin
        ev_r[i] = 1'b1;
        ed_r[i] = ~nib;
      end else if (inject_at >= 0 && j == inject_at + 1) begin
        ev_r[i] = 1'b0;
      end
      chk($sformatf("u%0d nib=%h stx c%0d", i, nib, j), get_stx(i), line[j]);
      chk($sformatf("u%0d nib=%h sr c%0d", i, nib, j), get_sr(i), 1'b0);
      chk($sformatf("u%0d nib=%h sbusy c%0d", i, nib, j), get_busy(i), 1'b1);
      step();
    end
    chk_idle(i, $sformatf("end nib=%h", nib));
  endtask

  task automatic send(int i, logic [3:0] nib);
    ed_r[i] = nib;
    ev_r[i] = 1'b1;
    step();
    ev_r[i] = 1'b0;
    check_frame(i, nib, -1, -1);
  endtask

  initial begin
    logic [3:0] nib;
    int         gap;

    for (int i = 0; i < 3; i++) begin
      ed_r[i] = 4'hF;
      ev_r[i] = 1'b1;
    end

    // Reset held for 3 cycles with a valid request pending
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < 3; i++) chk_idle(i, $sformatf("reset c%0d", c));
    end
    for (int i = 0; i < 3; i++) ev_r[i] = 1'b0;
    er = 1'b0;
    step();
    for (int i = 0; i < 3; i++) chk_idle(i, "post-reset");

    // Directed frames
    send(0, 4'b1011);
    send(1, 4'b0110);

    // Random frames on every configuration with random idle gaps
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        nib = 4'($urandom);
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) begin
          step();
          chk_idle(i, "gap");
        end
        send(i, nib);
      end
    end

    // Mid-frame ev with a different nibble is ignored
    ed_r[0] = 4'h3;
    ev_r[0] = 1'b1;
    step();
    ev_r[0] = 1'b0;
    check_frame(0, 4'h3, 9, -1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk_idle(0, $sformatf("after ignore c%0d", c));
    end

    // Back-to-back with ev held high: one idle cycle between frames
    ed_r[2] = 4'h0;
    ev_r[2] = 1'b1;
    step();
    ed_r[2] = 4'hF;
    check_frame(2, 4'h0, -1, -1);
    step();
    ev_r[2] = 1'b0;
    check_frame(2, 4'hF, -1, -1);
    step();
    chk_idle(2, "after b2b");

    // Reset during data bit 2 aborts asynchronously
    nib = 4'($urandom);
    ed_r[0] = nib;
    ev_r[0] = 1'b1;
    step();
    ev_r[0] = 1'b0;
    check_frame(0, nib, -1, 13);
    chk("u0 pre-abort stx", get_stx(0), nib[2]);
    er = 1'b1;
    #1;
    chk_idle(0, "async abort");
    step();
    step();
    chk_idle(0, "abort held");
    er = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_idle(0, $sformatf("no resume c%0d", c));
    end
    send(0, 4'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule

`default_nettype wire

// File: doc/nib_tx.md
# nib_tx

Serial transmitter for 4-bit words held in the datapath's nibble registers. It accepts a nibble over a valid/ready handshake and shifts it onto a single line as a framed serial word, LSB first. The frame is start, 4 data bits, optional even parity, then stop. This block is the read-out and transmit end for values written into register storage; a matching receiver elsewhere in the design consumes its line.

## Interface
- BIT_CYCLES, 4: clock cycles per serial bit; legal range 1..255.
- PARITY_EN, 1: 1 inserts an even-parity bit after d3; 0 omits it.

- eck  in  1  clock; all state changes on the rising edge.
- er  in  1  reset; asynchronous, active-high.
- ed  in  4  nibble to transmit; sampled only on the accepting edge.
- ev  in  1  ed valid.
- sr  out  1  ready; high only in IDLE.
- stx  out  1  serial line; idles high.
- sbusy  out  1  frame in progress; equals ~sr.

## Operation
- States and bit values:
  - IDLE: stx=1.
  - START: stx=0.
  - DATA: stx=shift[0].
  - PAR: stx=even parity of the latched nibble, i.e. ^data.
  - STOP: stx=1.
- Acceptance: on a rising edge with ev=1 and state IDLE:
  - latch ed into the shift register;
  - compute and latch parity;
  - clear the bit counter and the bit index;
  - go to START.
- ev in any other state is ignored. ed changes after acceptance do not affect the frame in progress.
- Bit counter: counts 0..BIT_CYCLES-1 in every non-IDLE state. On terminal count it resets to 0 and advances the FSM:
  - START -> DATA.
  - DATA: shift right and increment the index. After index 3 -> PAR if PARITY_EN, else STOP.
  - PAR -> STOP.
  - STOP -> IDLE.
- The counter is $clog2(BIT_CYCLES+1) bits wide. The index is 2 bits and never wraps inside a frame.
- All outputs are registered. stx is a flop, not decoded combinationally from state.
- Reset values: state=IDLE, stx=1, sr=1, sbusy=0, shift=0, counters=0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously: stx=1 and sr=1. No partial frame resumes after reset is released.
- ev held high continuously: the next nibble is accepted on the first edge in IDLE. This yields exactly one extra stop-level cycle between frames.

## Timing
- Frame length: F = (6 + PARITY_EN) * BIT_CYCLES cycles, from the accepting edge to the return to IDLE.
- stx goes low in the cycle right after the accepting edge (0 cycles of latency).
- Data bit k (0..3) occupies cycles [(1+k)*BIT_CYCLES, (2+k)*BIT_CYCLES), counted from the accepting edge.
- sr falls on the accepting edge and rises on the edge that ends the last STOP cycle. sr is low for exactly F cycles.
- Minimum accept-to-accept spacing is F+1 cycles.
- BIT_CYCLES=1: every bit lasts one cycle. This must work with no skipped or doubled bits.

## Test plan
- Reset: assert er for 3 cycles with ev=1, ed=4'hF. Required: stx=1, sr=1, sbusy=0 throughout, and no frame starts before er falls.
- Basic frame: BIT_CYCLES=4, PARITY_EN=1, ed=4'b1011. Required on stx, 4 cycles each: 0,1,1,0,1,1(parity),1(stop). sr is low for 28 cycles.
- No parity: BIT_CYCLES=1, PARITY_EN=0, ed=4'b0110. Required stx: 0,0,1,1,0,1. sr is low for exactly 6 cycles.
- Busy ignore: start a frame with ed=4'h3, then pulse ev with ed=4'hC mid-frame. Required: the 4'h3 frame completes unchanged, and 4'hC is never sent unless ev is presented again in IDLE.
- Back-to-back: hold ev=1 and send 4'h0 then 4'hF with BIT_CYCLES=2. Required: two frames separated by exactly one idle-high cycle. Parity is 0 for both words.
- Reset mid-frame: assert er during data bit 2. Required: stx=1 and sr=1 within the same cycle, asynchronously. After release, ed=4'h5 produces a complete, correct frame.
